// File: rtl/mux4_1_arb.sv
// Four-channel valid/ready mux with a one-beat output register and round-robin grant.
// Define MUX4_1_ARB_FIXED_PRIO_EN for fixed priority (channel 0 highest); ports are unchanged.
module mux4_1_arb #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [4*WIDTH-1:0] in_data,
    input  logic [3:0]         in_valid,
    output logic [3:0]         in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [1:0]         out_sel,
    output logic               out_valid,
    input  logic               out_ready
);

    logic [1:0] p;
    logic       load_en;
    logic       grant_any;
    logic [1:0] grant;
    logic [1:0] idx;

    always_comb begin
        load_en   = !out_valid || out_ready;
        grant_any = 1'b0;
        grant     = 2'b00;
        idx       = 2'b00;
`ifdef MUX4_1_ARB_FIXED_PRIO_EN
        // Scan from lowest priority upward so channel 0 wins last.
        for (int i = 3; i >= 0; i--) begin
            if (in_valid[i]) begin
                grant_any = 1'b1;
                grant     = 2'(i);
            end
        end
`else
        for (int i = 0; i < 4; i++) begin
            idx = p + 2'(i);
            if (!grant_any && in_valid[idx]) begin
                grant_any = 1'b1;
                grant     = idx;
            end
        end
`endif
        in_ready = 4'b0000;
        if (rst_n && load_en && grant_any) begin
            in_ready[grant] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= 2'b00;
            p         <= 2'b00;
        end else if (load_en) begin
            if (grant_any) begin
                out_valid <= 1'b1;
                out_data  <= in_data[int'(grant)*WIDTH +: WIDTH];
                out_sel   <= grant;
`ifdef MUX4_1_ARB_FIXED_PRIO_EN
                p         <= 2'b00;
`else
                p         <= grant + 2'd1;
`endif
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux4_1_arb.sv
// Directed bench for mux4_1_arb: expected beats are queued when a grant is expected
// and popped when the output handshake happens.
module tb_mux4_1_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_sel;
    logic        out_valid;
    logic        out_ready;

    int errors = 0;
    int checks = 0;
    logic [9:0] sb[$];

    mux4_1_arb #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_sel(out_sel),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Output side of the scoreboard: a handshake is decided by values stable at negedge.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_beat", {22'd0, out_sel, out_data}, 32'h3ff);
            end else begin
                logic [9:0] e;
                e = sb.pop_front();
                check("beat", {22'd0, out_sel, out_data}, {22'd0, e});
            end
        end
    end

    task automatic set_data(input logic [7:0] d0, d1, d2, d3);
        in_data = {d3, d2, d1, d0};
    endtask

    // One cycle: drive inputs, check in_ready, queue the expected beat, advance.
    task automatic step(input logic [3:0] iv, input logic rdy, input logic [3:0] exp_rdy);
        in_valid  = iv;
        out_ready = rdy;
        @(negedge clk);
        check("in_ready", {28'd0, in_ready}, {28'd0, exp_rdy});
        for (int k = 0; k < 4; k++) begin
            if (exp_rdy[k]) sb.push_back({2'(k), in_data[k*8 +: 8]});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [7:0] d, input logic [1:0] s);
        check({tag, "_valid"}, {31'd0, out_valid}, {31'd0, v});
        check({tag, "_data"},  {24'd0, out_data},  {24'd0, d});
        check({tag, "_sel"},   {30'd0, out_sel},   {30'd0, s});
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 4'b1111;
        out_ready = 1'b0;
        set_data(8'h10, 8'h11, 8'h12, 8'h13);
        @(negedge clk);
        check("in_ready_in_reset", {28'd0, in_ready}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        check_out("reset", 1'b0, 8'h00, 2'b00);
        rst_n    = 1'b1;
        in_valid = 4'b0000;

        // Single beat from channel 2, then drain to empty
        set_data(8'h10, 8'h11, 8'hA5, 8'h13);
        step(4'b0100, 1'b1, 4'b0100);
        check_out("single", 1'b1, 8'hA5, 2'b10);
        step(4'b0000, 1'b1, 4'b0000);
        check("drain_valid", {31'd0, out_valid}, 32'd0);

        // Pointer is now 3: wrap from channel 3 to channel 0
        set_data(8'h10, 8'h11, 8'h12, 8'h13);
        step(4'b1001, 1'b1, 4'b1000);
        step(4'b1001, 1'b1, 4'b0001);
        step(4'b0000, 1'b1, 4'b0000);
        check("wrap_empty", {31'd0, out_valid}, 32'd0);

        // Pointer is 1: load 0x77 from channel 1, hold it, then reset mid-operation
        set_data(8'h10, 8'h77, 8'h12, 8'h13);
        step(4'b0010, 1'b1, 4'b0010);
        step(4'b0000, 1'b0, 4'b0000);
        check_out("hold77", 1'b1, 8'h77, 2'b01);
        rst_n = 1'b0;
        step(4'b1111, 1'b0, 4'b0000);
        sb.delete();
        check_out("mid_reset", 1'b0, 8'h00, 2'b00);
        rst_n = 1'b1;

        // Round robin from channel 0 with all channels valid, one beat per cycle
        set_data(8'h10, 8'h11, 8'h12, 8'h13);
        step(4'b1111, 1'b1, 4'b0001);
        check_out("rr0", 1'b1, 8'h10, 2'b00);
        step(4'b1111, 1'b1, 4'b0010);
        step(4'b1111, 1'b1, 4'b0100);
        step(4'b1111, 1'b1, 4'b1000);
        step(4'b1111, 1'b1, 4'b0001);
        step(4'b1111, 1'b1, 4'b0010);

        // Backpressure on 0x33 from channel 2, then drain and load on the same edge
        set_data(8'h10, 8'h11, 8'h33, 8'h13);
        step(4'b1111, 1'b1, 4'b0100);
        for (int c = 0; c < 3; c++) begin
            step(4'b1111, 1'b0, 4'b0000);
            check_out("bp", 1'b1, 8'h33, 2'b10);
        end
        step(4'b1111, 1'b1, 4'b1000);
        check_out("bp_reload", 1'b1, 8'h13, 2'b11);
        step(4'b0000, 1'b1, 4'b0000);
        step(4'b0000, 1'b1, 4'b0000);
        check("final_empty", {31'd0, out_valid}, 32'd0);
        check("sb_empty", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
